// File: rtl/lifi_pkg.sv
`default_nettype none
// ============================================================================
// Module   : lifi_pkg
// Purpose  : Shared constants and FSM state encoding for the Li-Fi RX serializer.
// Revision : 1.0  initial release
// ============================================================================
package lifi_pkg;

    localparam int M     = 8;
    localparam int N     = 16;
    localparam int SYM_W = M / 4;
    localparam int FW    = (N - 1) * SYM_W;
    localparam int CNT_W = $clog2(FW + 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_PARITY = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/frame_fifo2.sv
`default_nettype none
// ============================================================================
// Module   : frame_fifo2
// Purpose  : Two-entry frame FIFO; a push while full is dropped unless a pop
//            happens in the same cycle.
// Revision : 1.0  initial release
// ============================================================================
module frame_fifo2 #(
    parameter int WIDTH = lifi_pkg::FW
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic [1:0]       o_count,
    output logic             o_empty,
    output logic             o_drop
);
    import lifi_pkg::*;

    logic [WIDTH-1:0] r_mem [2];
    logic             r_wr_ptr;
    logic             r_rd_ptr;
    logic [1:0]       r_count;

    logic w_full;
    logic w_do_pop;
    logic w_do_push;

    assign w_full    = (r_count == 2'd2);
    assign o_empty   = (r_count == 2'd0);
    assign w_do_pop  = i_pop & ~o_empty;
    // A pop frees the slot in the same cycle, so a full FIFO still accepts.
    assign w_do_push = i_push & (~w_full | w_do_pop);
    assign o_drop    = i_push & w_full & ~w_do_pop;
    assign o_data    = r_mem[r_rd_ptr];
    assign o_count   = r_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr] <= i_data;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (w_do_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/pam_bit_serializer.sv
`default_nettype none
// ============================================================================
// Module   : pam_bit_serializer
// Purpose  : Buffers demapped PAM frames and streams them out bit-serially.
//            Optional trailing even-parity bit: define SERIAL_PARITY_EN.
// Revision : 1.0  initial release
// ============================================================================
module pam_bit_serializer #(
    parameter int M  = 8,
    parameter int N  = 16,
    parameter int FW = (N - 1) * (M / 4)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    input  logic [FW-1:0] in_data,
    output logic          bit_out,
    output logic          bit_valid,
    input  logic          bit_ready,
    output logic          frame_start,
    output logic          frame_end,
    output logic          overflow,
    output logic          busy
);
    import lifi_pkg::*;

    localparam int                 C_SYM_W = M / 4;
    localparam int                 C_NSYM  = FW / C_SYM_W;
    localparam int                 C_CNT_W = $clog2(FW + 1);
    localparam logic [C_CNT_W-1:0] C_LAST  = C_CNT_W'(FW - 1);

    state_t             r_state;
    state_t             w_next;
    logic [FW-1:0]      r_shift;
    logic [C_CNT_W-1:0] r_bit_cnt;
    logic               r_overflow;
    logic               w_pop;
    logic               w_xfer;
    logic [FW-1:0]      w_head;
    logic [FW-1:0]      w_ordered;
    logic [1:0]         w_count;
    logic               w_empty;
    logic               w_drop;
`ifdef SERIAL_PARITY_EN
    logic               r_par;
`endif

    frame_fifo2 #(
        .WIDTH (FW)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (in_valid),
        .i_data  (in_data),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_count (w_count),
        .o_empty (w_empty),
        .o_drop  (w_drop)
    );

    // Reorder so the MSB of the shifter is always the next bit on the wire:
    // symbol 0 first, MSB-first within each symbol.
    for (genvar k = 0; k < C_NSYM; k++) begin : g_sym
        for (genvar b = 0; b < C_SYM_W; b++) begin : g_bit
            assign w_ordered[FW-1-(k*C_SYM_W+(C_SYM_W-1-b))] = w_head[k*C_SYM_W+b];
        end
    end

    assign w_xfer = bit_valid & bit_ready;

    always_comb begin
        w_next = r_state;
        w_pop  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!w_empty) begin
                    w_pop  = 1'b1;
                    w_next = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (w_xfer && (r_bit_cnt == C_LAST)) begin
`ifdef SERIAL_PARITY_EN
                    w_next = ST_PARITY;
`else
                    w_pop  = ~w_empty;
                    w_next = w_empty ? ST_IDLE : ST_SHIFT;
`endif
                end
            end
`ifdef SERIAL_PARITY_EN
            ST_PARITY: begin
                if (w_xfer) begin
                    w_pop  = ~w_empty;
                    w_next = w_empty ? ST_IDLE : ST_SHIFT;
                end
            end
`endif
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_shift    <= '0;
            r_bit_cnt  <= '0;
            r_overflow <= 1'b0;
`ifdef SERIAL_PARITY_EN
            r_par      <= 1'b0;
`endif
        end else begin
            r_state    <= w_next;
            r_overflow <= r_overflow | w_drop;
            if (w_pop) begin
                r_shift   <= w_ordered;
                r_bit_cnt <= '0;
`ifdef SERIAL_PARITY_EN
                r_par     <= ^w_head;
`endif
            end else if ((r_state == ST_SHIFT) && w_xfer) begin
                r_shift   <= {r_shift[FW-2:0], 1'b0};
                r_bit_cnt <= r_bit_cnt + 1'b1;
            end
        end
    end

    assign bit_valid   = (r_state != ST_IDLE);
    assign frame_start = (r_state == ST_SHIFT) && (r_bit_cnt == '0);
`ifdef SERIAL_PARITY_EN
    assign bit_out     = (r_state == ST_PARITY) ? r_par : ((r_state == ST_SHIFT) & r_shift[FW-1]);
    assign frame_end   = (r_state == ST_PARITY);
`else
    assign bit_out     = (r_state == ST_SHIFT) & r_shift[FW-1];
    assign frame_end   = (r_state == ST_SHIFT) && (r_bit_cnt == C_LAST);
`endif
    assign overflow    = r_overflow;
    assign busy        = (w_count != 2'd0) || (r_state != ST_IDLE);

endmodule
`default_nettype wire
